mc14500b_sequencer: RTL and testbench
=====================================

MC14500B_SEQUENCER -- requirements
Module: mc14500b_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: X2 clock (rising edge), RST_N async active-low reset.
REQ-002 Ports SHALL be:
- X2  in  1  system clock
- RST_N  in  1  async active-low reset
- INSTR  out  4  opcode to ICU, IR[11:8]
- DATA  inout  1  ICU data bus; driven by sequencer when WRITE=0, Z when WRITE=1
- RR, WRITE, JMP, RTN, FLG0, FLGF  in  1 each  ICU status outputs
- rom_addr  out  8  program memory address (= PC)
- rom_data  in  12  program word: [11:8] opcode, [7:0] operand address
- in_port  in  8  external input pins
- out_port  out  8  addressable output latch
- halted  out  1  sequencer stopped by FLGF
- stack_err  out  1  sticky return-stack fault (only with SEQ_STACK_EN)

Function
REQ-003 PC (8-bit) SHALL drive rom_addr combinationally; IR (12-bit) SHALL load rom_data on each rising X2 edge; PC SHALL increment by 1 per edge, wrapping 0xFF->0x00.
REQ-004 INSTR SHALL equal IR[11:8]; operand address A = IR[7:0].
REQ-005 Input mux: A[3]=0 -> DATA = in_port[A[2:0]]; A[3]=1 -> DATA = out_port[A[2:0]] (readback); A[7:4] ignored for I/O.
REQ-006 On a rising edge with WRITE=1 and A[3]=1, out_port[A[2:0]] SHALL take DATA; WRITE=1 with A[3]=0 SHALL change nothing.
REQ-007 Status inputs SHALL be sampled on the rising X2 edge; priority FLGF > RTN > JMP > FLG0 > sequential.
REQ-008 JMP=1: PC <= A; IR <= 0x000 (NOP0 bubble); exactly one bubble cycle before the target word executes.
REQ-009 RTN=1: behaviour per Configuration; IR <= 0x000 in all cases, since the ICU skips the following instruction.
REQ-010 FLGF=1: halted <= 1; PC frozen; IR <= 0x000 every edge thereafter; only RST_N clears it.
REQ-011 FLG0=1: out_port <= 0x00 at that edge; a WRITE in the same cycle is overridden.
REQ-012 While halted, WRITE, JMP, RTN and FLG0 SHALL be ignored.

Reset
REQ-013 RST_N=0 SHALL asynchronously force PC=0x00, IR=0x000, out_port=0x00, halted=0, stack_err=0, stack pointer=0, and DATA driven.
REQ-014 Reset mid-operation SHALL abandon any pending jump or return; the first word fetched after release comes from address 0x00.

Configuration
REQ-015 Macro SEQ_STACK_EN SHALL be defined: 4-entry return stack; JMP pushes PC (the address after the JMP word) then jumps; RTN pops into PC.
REQ-016 Stack push when full SHALL overwrite the oldest entry (circular) and set stack_err; RTN when empty SHALL leave PC sequential and set stack_err.
REQ-017 Without SEQ_STACK_EN, the block SHALL have no stack logic, JMP SHALL be a plain jump, RTN SHALL only insert the NOP0 bubble, and stack_err SHALL be tied to 0.

Verification
REQ-018 Reset, ROM of NOP0 words -> rom_addr steps 0x00, 0x01, 0x02...; wraps 0xFF->0x00; out_port=0x00.
REQ-019 Word 0x1_03 (LD) with in_port=0x08, then 0x1_03 with in_port=0x00 -> DATA=1 then 0; word with A=0x0B -> DATA=out_port[3].
REQ-020 WRITE=1 with A=0x0A, DATA=1 -> out_port=0x04 next edge; WRITE=1 with A=0x02 -> out_port unchanged.
REQ-021 JMP=1 with A=0x40 at PC=0x11 -> next IR=0x000, then rom_addr=0x40; with SEQ_STACK_EN, a later RTN -> PC=0x11 after one bubble.
REQ-022 With SEQ_STACK_EN: 5 nested JMPs -> stack_err=1 and oldest return lost; RTN on empty stack -> stack_err=1 and PC sequential.
REQ-023 FLGF=1 at PC=0x20 -> halted=1, rom_addr held 0x20, INSTR=0; FLG0 with out_port=0xFF -> 0x00; RST_N pulse mid-run -> all REQ-013 values immediately.

Source files
------------

// File: rtl/mc14500b_sequencer.sv
// Program-counter / IR / I/O sequencer for an MC14500B ICU.
// Optional 4-entry return stack enabled by defining SEQ_STACK_EN.
module mc14500b_sequencer (
   input  logic        X2,
   input  logic        RST_N,
   output logic [3:0]  INSTR,
   inout  wire         DATA,
   input  logic        RR,
   input  logic        WRITE,
   input  logic        JMP,
   input  logic        RTN,
   input  logic        FLG0,
   input  logic        FLGF,
   output logic [7:0]  rom_addr,
   input  logic [11:0] rom_data,
   input  logic [7:0]  in_port,
   output logic [7:0]  out_port,
   output logic        halted,
   output logic        stack_err
);

   logic [7:0]  r_pc;
   logic [11:0] r_ir;
   logic [7:0]  r_out;
   logic        r_halted;

   logic [7:0]  w_a;
   logic        w_din;
   logic        w_active;
   logic [7:0]  w_pc_d;
   logic [11:0] w_ir_d;
   logic [7:0]  w_out_d;
   logic        w_push;
   logic        w_pop;
   logic        w_unused;

   assign w_unused = RR;
   assign w_a      = r_ir[7:0];
   assign INSTR    = r_ir[11:8];
   assign rom_addr = r_pc;
   assign out_port = r_out;
   assign halted   = r_halted;
   assign w_active = !r_halted && !FLGF;

   // A[3] selects readback of the output latch instead of the input pins.
   assign w_din = w_a[3] ? r_out[w_a[2:0]] : in_port[w_a[2:0]];
   assign DATA  = (WRITE && RST_N) ? 1'bz : w_din;

`ifdef SEQ_STACK_EN
   logic [7:0] r_stk [4];
   logic [1:0] r_wp;
   logic [2:0] r_cnt;
   logic       r_err;
   logic [1:0] w_wp_m1;
   logic       w_empty;

   assign w_wp_m1   = r_wp - 2'd1;
   assign w_empty   = (r_cnt == 3'd0);
   assign stack_err = r_err;
`else
   assign stack_err = 1'b0;
`endif

   always_comb begin
      w_pc_d = r_pc + 8'd1;
      w_ir_d = rom_data;
      w_push = 1'b0;
      w_pop  = 1'b0;
      if (!w_active) begin
         w_pc_d = r_pc;
         w_ir_d = 12'h000;
      end else if (RTN) begin
         w_ir_d = 12'h000;
         w_pop  = 1'b1;
`ifdef SEQ_STACK_EN
         if (!w_empty) w_pc_d = r_stk[w_wp_m1];
`endif
      end else if (JMP) begin
         w_pc_d = w_a;
         w_ir_d = 12'h000;
         w_push = 1'b1;
      end
   end

   always_comb begin
      w_out_d = r_out;
      if (w_active && FLG0) begin
         w_out_d = 8'h00;
      end else if (w_active && WRITE && w_a[3]) begin
         w_out_d[w_a[2:0]] = DATA;
      end
   end

   always_ff @(posedge X2 or negedge RST_N) begin
      if (!RST_N) begin
         r_pc     <= 8'h00;
         r_ir     <= 12'h000;
         r_out    <= 8'h00;
         r_halted <= 1'b0;
      end else begin
         r_pc  <= w_pc_d;
         r_ir  <= w_ir_d;
         r_out <= w_out_d;
         if (w_active && FLGF) r_halted <= 1'b1;
         else if (FLGF && !r_halted) r_halted <= 1'b1;
      end
   end

`ifdef SEQ_STACK_EN
   // Entries need no reset: the occupancy count gates every read.
   always_ff @(posedge X2) begin
      if (w_push) r_stk[r_wp] <= r_pc;
   end

   always_ff @(posedge X2 or negedge RST_N) begin
      if (!RST_N) begin
         r_wp  <= 2'd0;
         r_cnt <= 3'd0;
         r_err <= 1'b0;
      end else if (w_push) begin
         r_wp <= r_wp + 2'd1;
         if (r_cnt == 3'd4) r_err <= 1'b1;
         else r_cnt <= r_cnt + 3'd1;
      end else if (w_pop) begin
         if (w_empty) begin
            r_err <= 1'b1;
         end else begin
            r_wp  <= w_wp_m1;
            r_cnt <= r_cnt - 3'd1;
         end
      end
   end
`else
   logic w_unused_flow;
   assign w_unused_flow = w_push | w_pop;
`endif

endmodule

// File: tb/tb_mc14500b_sequencer.sv
// Directed self-checking bench for mc14500b_sequencer.
// Stack sequences are compiled in only when SEQ_STACK_EN is defined.
module tb_mc14500b_sequencer;

   logic        X2;
   logic        RST_N;
   logic [3:0]  INSTR;
   wire         DATA;
   logic        RR, WRITE, JMP, RTN, FLG0, FLGF;
   logic [7:0]  rom_addr;
   logic [11:0] rom_data;
   logic [7:0]  in_port;
   logic [7:0]  out_port;
   logic        halted;
   logic        stack_err;
   logic        tb_d;

   int checks;
   int failures;

   assign DATA = WRITE ? tb_d : 1'bz;

   mc14500b_sequencer dut (
      .X2        (X2),
      .RST_N     (RST_N),
      .INSTR     (INSTR),
      .DATA      (DATA),
      .RR        (RR),
      .WRITE     (WRITE),
      .JMP       (JMP),
      .RTN       (RTN),
      .FLG0      (FLG0),
      .FLGF      (FLGF),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .in_port   (in_port),
      .out_port  (out_port),
      .halted    (halted),
      .stack_err (stack_err)
   );

   initial X2 = 1'b0;
   always #5 X2 = ~X2;

   typedef struct {
      logic [11:0] rom;
      logic [7:0]  inp;
      logic        wr;
      logic        f0;
      logic        d;
      logic [7:0]  e_addr;
      logic [3:0]  e_instr;
      logic        chk_d;
      logic        e_d;
      logic [7:0]  e_out;
   } vec_t;

   vec_t vt [13];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step(input logic [11:0] rom, input logic [7:0] inp, input logic wr,
                       input logic jmp, input logic rtn, input logic f0, input logic ff,
                       input logic d);
      rom_data = rom;
      in_port  = inp;
      WRITE    = wr;
      JMP      = jmp;
      RTN      = rtn;
      FLG0     = f0;
      FLGF     = ff;
      tb_d     = d;
      @(posedge X2);
      #1;
   endtask

   task automatic nop(input int n);
      for (int i = 0; i < n; i++) step(12'h000, 8'h00, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      WRITE = 0; JMP = 0; RTN = 0; FLG0 = 0; FLGF = 0; RR = 0;
      rom_data = 12'h000; in_port = 8'h00; tb_d = 0;
      RST_N = 0;
      @(negedge X2);
      RST_N = 1;
   endtask

   // Sets every output bit via STO-style writes to A=0x08..0x0F.
   task automatic set_all_ones();
      logic [11:0] w;
      for (int k = 0; k < 8; k++) begin
         w = 12'h808 | 12'(k);
         step(w, 8'h00, 0, 0, 0, 0, 0, 0);
         step(12'h000, 8'h00, 1, 0, 0, 0, 0, 1);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      WRITE = 0; JMP = 0; RTN = 0; FLG0 = 0; FLGF = 0; RR = 0;
      rom_data = 12'h000; in_port = 8'h00; tb_d = 0;
      RST_N = 0;
      #1;
      chk("rst_addr", 16'(rom_addr), 16'h00);
      chk("rst_instr", 16'(INSTR), 16'h0);
      chk("rst_out", 16'(out_port), 16'h00);
      chk("rst_halt", 16'(halted), 16'h0);
      chk("rst_serr", 16'(stack_err), 16'h0);
      @(negedge X2);
      RST_N = 1;

      // rom, inp, wr, f0, d, e_addr, e_instr, chk_d, e_d, e_out
      vt[0]  = '{12'h000, 8'h00, 0, 0, 0, 8'h01, 4'h0, 1, 0, 8'h00};
      vt[1]  = '{12'h103, 8'h08, 0, 0, 0, 8'h02, 4'h1, 1, 1, 8'h00};
      vt[2]  = '{12'h103, 8'h00, 0, 0, 0, 8'h03, 4'h1, 1, 0, 8'h00};
      vt[3]  = '{12'h80A, 8'h00, 0, 0, 0, 8'h04, 4'h8, 1, 0, 8'h00};
      vt[4]  = '{12'h000, 8'h00, 1, 0, 1, 8'h05, 4'h0, 0, 0, 8'h04};
      vt[5]  = '{12'h802, 8'h00, 0, 0, 0, 8'h06, 4'h8, 1, 0, 8'h04};
      vt[6]  = '{12'h000, 8'h00, 1, 0, 1, 8'h07, 4'h0, 0, 0, 8'h04};
      vt[7]  = '{12'h10A, 8'h00, 0, 0, 0, 8'h08, 4'h1, 1, 1, 8'h04};
      vt[8]  = '{12'h10B, 8'h00, 0, 0, 0, 8'h09, 4'h1, 1, 0, 8'h04};
      vt[9]  = '{12'h1F3, 8'h08, 0, 0, 0, 8'h0A, 4'h1, 1, 1, 8'h04};
      vt[10] = '{12'h000, 8'h00, 0, 1, 0, 8'h0B, 4'h0, 1, 0, 8'h00};
      vt[11] = '{12'h80A, 8'h00, 0, 0, 0, 8'h0C, 4'h8, 1, 0, 8'h00};
      vt[12] = '{12'h000, 8'h00, 1, 1, 1, 8'h0D, 4'h0, 0, 0, 8'h00};

      for (int i = 0; i < 13; i++) begin
         step(vt[i].rom, vt[i].inp, vt[i].wr, 0, 0, vt[i].f0, 0, vt[i].d);
         chk($sformatf("v%0d_addr", i), 16'(rom_addr), 16'(vt[i].e_addr));
         chk($sformatf("v%0d_instr", i), 16'(INSTR), 16'(vt[i].e_instr));
         chk($sformatf("v%0d_out", i), 16'(out_port), 16'(vt[i].e_out));
         chk($sformatf("v%0d_halt", i), 16'(halted), 16'h0);
         if (vt[i].chk_d) chk($sformatf("v%0d_data", i), 16'(DATA), 16'(vt[i].e_d));
      end

      // PC walk and wrap
      do_reset();
      for (int i = 0; i < 256; i++) begin
         nop(1);
         chk($sformatf("wrap%0d", i), 16'(rom_addr), 16'((i + 1) % 256));
      end
      chk("wrap_out", 16'(out_port), 16'h00);

      // Plain jump with one bubble, then return
      do_reset();
      nop(16);
      step(12'hC40, 8'h00, 0, 0, 0, 0, 0, 0);
      chk("jmp_pre_addr", 16'(rom_addr), 16'h11);
      chk("jmp_pre_instr", 16'(INSTR), 16'hC);
      step(12'h555, 8'h00, 0, 1, 0, 0, 0, 0);
      chk("jmp_bubble", 16'(INSTR), 16'h0);
      chk("jmp_target", 16'(rom_addr), 16'h40);
      step(12'h123, 8'h00, 0, 0, 0, 0, 0, 0);
      chk("jmp_exec_instr", 16'(INSTR), 16'h1);
      chk("jmp_exec_addr", 16'(rom_addr), 16'h41);
      step(12'hD00, 8'h00, 0, 0, 0, 0, 0, 0);
      step(12'h555, 8'h00, 0, 0, 1, 0, 0, 0);
      chk("rtn_bubble", 16'(INSTR), 16'h0);
`ifdef SEQ_STACK_EN
      chk("rtn_addr", 16'(rom_addr), 16'h11);
`else
      chk("rtn_addr", 16'(rom_addr), 16'h43);
`endif
      chk("rtn_serr", 16'(stack_err), 16'h0);

`ifdef SEQ_STACK_EN
      // Five nested calls overflow the 4-deep stack
      do_reset();
      for (int j = 1; j <= 5; j++) begin
         logic [11:0] w;
         w = 12'hC00 | 12'(j * 16);
         step(w, 8'h00, 0, 0, 0, 0, 0, 0);
         step(12'h555, 8'h00, 0, 1, 0, 0, 0, 0);
         chk($sformatf("nest%0d_addr", j), 16'(rom_addr), 16'(j * 16));
         chk($sformatf("nest%0d_serr", j), 16'(stack_err), 16'(j == 5 ? 1 : 0));
      end
      for (int j = 4; j >= 1; j--) begin
         step(12'hD00, 8'h00, 0, 0, 0, 0, 0, 0);
         step(12'h555, 8'h00, 0, 0, 1, 0, 0, 0);
         chk($sformatf("pop%0d_addr", j), 16'(rom_addr), 16'(j * 16 + 1));
      end
      step(12'hD00, 8'h00, 0, 0, 0, 0, 0, 0);
      step(12'h555, 8'h00, 0, 0, 1, 0, 0, 0);
      chk("pop_lost_addr", 16'(rom_addr), 16'h13);

      // Return on an empty stack
      do_reset();
      step(12'hD00, 8'h00, 0, 0, 0, 0, 0, 0);
      chk("empty_pre_serr", 16'(stack_err), 16'h0);
      step(12'h555, 8'h00, 0, 0, 1, 0, 0, 0);
      chk("empty_addr", 16'(rom_addr), 16'h02);
      chk("empty_serr", 16'(stack_err), 16'h1);
`endif

      // FLG0 clears a full latch
      do_reset();
      set_all_ones();
      chk("ones_out", 16'(out_port), 16'hFF);
      step(12'h000, 8'h00, 0, 0, 0, 1, 0, 0);
      chk("flg0_out", 16'(out_port), 16'h00);

      // Halt at 0x20, status ignored while halted, then async reset
      do_reset();
      set_all_ones();
      nop(16);
      chk("pre_halt_addr", 16'(rom_addr), 16'h20);
      step(12'h555, 8'h00, 0, 0, 0, 0, 1, 0);
      chk("halt_flag", 16'(halted), 16'h1);
      chk("halt_addr", 16'(rom_addr), 16'h20);
      chk("halt_instr", 16'(INSTR), 16'h0);
      for (int i = 0; i < 3; i++) begin
         step(12'h555, 8'h00, 0, 1, 1, 1, 0, 0);
         chk($sformatf("held%0d_addr", i), 16'(rom_addr), 16'h20);
         chk($sformatf("held%0d_instr", i), 16'(INSTR), 16'h0);
         chk($sformatf("held%0d_out", i), 16'(out_port), 16'hFF);
         chk($sformatf("held%0d_halt", i), 16'(halted), 16'h1);
      end
      JMP = 0; RTN = 0; FLG0 = 0;
      in_port = 8'h01;
      #1;
      RST_N = 0;
      #1;
      chk("async_addr", 16'(rom_addr), 16'h00);
      chk("async_instr", 16'(INSTR), 16'h0);
      chk("async_out", 16'(out_port), 16'h00);
      chk("async_halt", 16'(halted), 16'h0);
      chk("async_serr", 16'(stack_err), 16'h0);
      chk("async_data", 16'(DATA), 16'h1);
      @(negedge X2);
      RST_N = 1;
      nop(1);
      chk("post_rst_addr", 16'(rom_addr), 16'h01);

      // Reset while a jump is pending abandons it
      do_reset();
      step(12'hC40, 8'h00, 0, 0, 0, 0, 0, 0);
      JMP = 1;
      #2;
      RST_N = 0;
      #1;
      chk("pend_rst_addr", 16'(rom_addr), 16'h00);
      @(negedge X2);
      JMP = 0;
      RST_N = 1;
      nop(1);
      chk("pend_addr", 16'(rom_addr), 16'h01);
      chk("pend_instr", 16'(INSTR), 16'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
